// File: rtl/fsm_mestre_envase.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_mestre_envase
//  Description : Master sequencer for the bottling line. It moves the conveyor,
//                runs the filling and capping slaves through a level-hold
//                cmd/done handshake, then counts and releases each bottle.
//                Optional handshake watchdog enabled by macro WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_mestre_envase #(
    parameter int TIMEOUT_CICLOS = 250000000,
    parameter int CONT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              habilitar,
    input  logic              sensor_posicao,
    input  logic              concluido_encher,
    input  logic              concluido_vedar,
    input  logic              reconhecer,
    output logic              motor_esteira,
    output logic              cmd_encher,
    output logic              cmd_vedar,
    output logic [CONT_W-1:0] contagem,
    output logic              alarme,
    output logic              ocupado
);

    localparam logic [3:0] c_IDLE         = 4'd0;
    localparam logic [3:0] c_TRANSPORTE   = 4'd1;
    localparam logic [3:0] c_ENCHE_CMD    = 4'd2;
    localparam logic [3:0] c_ENCHE_LIBERA = 4'd3;
    localparam logic [3:0] c_VEDA_CMD     = 4'd4;
    localparam logic [3:0] c_VEDA_LIBERA  = 4'd5;
    localparam logic [3:0] c_CONTA        = 4'd6;
    localparam logic [3:0] c_SAIDA        = 4'd7;
    localparam logic [3:0] c_FALHA        = 4'd8;

    logic [3:0]        r_estado;
    logic [3:0]        w_proximo;
    logic [CONT_W-1:0] r_contagem;
    logic              w_timeout;

`ifdef WATCHDOG_EN
    localparam int c_WDT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [c_WDT_W-1:0] c_WDT_MAX = c_WDT_W'(TIMEOUT_CICLOS - 1);

    logic [c_WDT_W-1:0] r_wdt;
    logic               w_em_handshake;

    assign w_em_handshake = (r_estado == c_ENCHE_CMD)    ||
                            (r_estado == c_ENCHE_LIBERA) ||
                            (r_estado == c_VEDA_CMD)     ||
                            (r_estado == c_VEDA_LIBERA);

    // Counter restarts on every state change, so each handshake wait gets its own budget
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdt <= '0;
        end else if (w_proximo != r_estado) begin
            r_wdt <= '0;
        end else if (w_em_handshake) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

    assign w_timeout = (r_wdt == c_WDT_MAX);
`else
    assign w_timeout = 1'b0;
`endif

    // Exit conditions are tested before the timeout so a late done still wins
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            c_IDLE: begin
                if (habilitar) begin
                    w_proximo = c_TRANSPORTE;
                end
            end
            c_TRANSPORTE: begin
                if (sensor_posicao) begin
                    w_proximo = c_ENCHE_CMD;
                end else if (!habilitar) begin
                    w_proximo = c_IDLE;
                end
            end
            c_ENCHE_CMD: begin
                if (concluido_encher) begin
                    w_proximo = c_ENCHE_LIBERA;
                end else if (w_timeout) begin
                    w_proximo = c_FALHA;
                end
            end
            c_ENCHE_LIBERA: begin
                if (!concluido_encher) begin
                    w_proximo = c_VEDA_CMD;
                end else if (w_timeout) begin
                    w_proximo = c_FALHA;
                end
            end
            c_VEDA_CMD: begin
                if (concluido_vedar) begin
                    w_proximo = c_VEDA_LIBERA;
                end else if (w_timeout) begin
                    w_proximo = c_FALHA;
                end
            end
            c_VEDA_LIBERA: begin
                if (!concluido_vedar) begin
                    w_proximo = c_CONTA;
                end else if (w_timeout) begin
                    w_proximo = c_FALHA;
                end
            end
            c_CONTA: begin
                w_proximo = c_SAIDA;
            end
            c_SAIDA: begin
                if (!sensor_posicao) begin
                    w_proximo = habilitar ? c_TRANSPORTE : c_IDLE;
                end
            end
            c_FALHA: begin
                if (reconhecer) begin
                    w_proximo = c_IDLE;
                end
            end
            default: begin
                w_proximo = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= c_IDLE;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (r_estado == c_CONTA) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    // Moore decode straight off the state register: async reset drops commands at once
    assign motor_esteira = (r_estado == c_TRANSPORTE) || (r_estado == c_SAIDA);
    assign cmd_encher    = (r_estado == c_ENCHE_CMD);
    assign cmd_vedar     = (r_estado == c_VEDA_CMD);
    assign contagem      = r_contagem;
    assign ocupado       = (r_estado == c_TRANSPORTE)   ||
                           (r_estado == c_ENCHE_CMD)    ||
                           (r_estado == c_ENCHE_LIBERA) ||
                           (r_estado == c_VEDA_CMD)     ||
                           (r_estado == c_VEDA_LIBERA)  ||
                           (r_estado == c_CONTA)        ||
                           (r_estado == c_SAIDA);

`ifdef WATCHDOG_EN
    assign alarme = (r_estado == c_FALHA);
`else
    assign alarme = 1'b0;
`endif

endmodule
`default_nettype wire
